// File: rtl/gb_interrupt_timer.sv
// Game Boy DIV/TIMA/TMA/TAC timer with the IF/IE interrupt registers.
// Bus writes are single-cycle strobes: wr_en with a selected addr_i commits data_i at the next rising edge.
module gb_interrupt_timer (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] addr_i,
    input  logic [7:0]  data_i,
    input  logic        wr_en,
    output logic [7:0]  data_o,
    output logic        sel_o,
    input  logic        irq_vblank,
    input  logic        irq_stat,
    input  logic        irq_serial,
    input  logic        irq_joypad,
    input  logic        clear_interrupt_flag,
    output logic [7:0]  reg_IF,
    output logic [7:0]  reg_IE,
    output logic [1:0]  fsm_state
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        OVF    = 2'd1,
        RELOAD = 2'd2
    } state_t;

    state_t      state;
    logic [15:0] counter;
    logic [7:0]  tima;
    logic [7:0]  tma;
    logic [2:0]  tac;
    logic [4:0]  if_q;
    logic [7:0]  ie;
    logic        timer_prev;

    logic        wr_div, wr_tima, wr_tma, wr_tac, wr_if, wr_ie;
    logic        timer_bit, timer_sig, timer_fall, timer_irq;
    logic [4:0]  if_cleared, if_next;

    assign wr_div  = wr_en && (addr_i == 16'hFF04);
    assign wr_tima = wr_en && (addr_i == 16'hFF05);
    assign wr_tma  = wr_en && (addr_i == 16'hFF06);
    assign wr_tac  = wr_en && (addr_i == 16'hFF07);
    assign wr_if   = wr_en && (addr_i == 16'hFF0F);
    assign wr_ie   = wr_en && (addr_i == 16'hFFFF);

    always_comb begin
        case (tac[1:0])
            2'b00:   timer_bit = counter[9];
            2'b01:   timer_bit = counter[3];
            2'b10:   timer_bit = counter[5];
            default: timer_bit = counter[7];
        endcase
    end

    assign timer_sig  = tac[2] & timer_bit;
    assign timer_fall = timer_prev & ~timer_sig;
    // A TIMA write during OVF cancels both the reload and the interrupt.
    assign timer_irq  = (state == OVF) && !wr_tima;

    // x & (x - 1) drops the lowest set bit, which is the highest-priority request.
    assign if_cleared = clear_interrupt_flag ? (if_q & (if_q - 5'd1)) : if_q;
    assign if_next    = (wr_if ? data_i[4:0] : if_cleared)
                      | {irq_joypad, irq_serial, timer_irq, irq_stat, irq_vblank};

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= RUN;
            counter    <= 16'h0000;
            tima       <= 8'h00;
            tma        <= 8'h00;
            tac        <= 3'b000;
            if_q       <= 5'b00000;
            ie         <= 8'h00;
            timer_prev <= 1'b0;
        end else begin
            counter    <= wr_div ? 16'h0000 : counter + 16'd4;
            timer_prev <= timer_sig;
            if_q       <= if_next;
            if (wr_tma) tma <= data_i;
            if (wr_tac) tac <= data_i[2:0];
            if (wr_ie)  ie  <= data_i;

            case (state)
                RUN: begin
                    if (wr_tima) begin
                        tima <= data_i;
                    end else if (timer_fall) begin
                        tima <= tima + 8'd1;
                        if (tima == 8'hFF) state <= OVF;
                    end
                end
                OVF: begin
                    if (wr_tima) begin
                        tima  <= data_i;
                        state <= RUN;
                    end else begin
                        tima  <= tma;
                        state <= RELOAD;
                    end
                end
                RELOAD: begin
                    // TMA written now is what the reloaded TIMA must hold.
                    if (wr_tma) tima <= data_i;
                    state <= RUN;
                end
                default: state <= RUN;
            endcase
        end
    end

    always_comb begin
        sel_o  = 1'b1;
        data_o = 8'hFF;
        case (addr_i)
            16'hFF04: data_o = counter[15:8];
            16'hFF05: data_o = tima;
            16'hFF06: data_o = tma;
            16'hFF07: data_o = {5'b11111, tac};
            16'hFF0F: data_o = {3'b111, if_q};
            16'hFFFF: data_o = ie;
            default:  sel_o  = 1'b0;
        endcase
    end

    assign reg_IF    = {3'b000, if_q};
    assign reg_IE    = ie;
    assign fsm_state = state;

endmodule

// File: tb/tb_gb_interrupt_timer.sv
// Bench for gb_interrupt_timer: register table, overflow/interrupt sequences,
// then random traffic compared against a cycle-level reference model.
module tb_gb_interrupt_timer;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] addr_i;
    logic [7:0]  data_i;
    logic        wr_en;
    logic [7:0]  data_o;
    logic        sel_o;
    logic        irq_vblank, irq_stat, irq_serial, irq_joypad;
    logic        clear_interrupt_flag;
    logic [7:0]  reg_IF, reg_IE;
    logic [1:0]  fsm_state;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    gb_interrupt_timer dut (
        .clk(clk), .reset(reset), .addr_i(addr_i), .data_i(data_i), .wr_en(wr_en),
        .data_o(data_o), .sel_o(sel_o),
        .irq_vblank(irq_vblank), .irq_stat(irq_stat), .irq_serial(irq_serial),
        .irq_joypad(irq_joypad), .clear_interrupt_flag(clear_interrupt_flag),
        .reg_IF(reg_IF), .reg_IE(reg_IE), .fsm_state(fsm_state)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        reset = 1'b0; wr_en = 1'b0; addr_i = 16'h0000; data_i = 8'h00;
        irq_vblank = 1'b0; irq_stat = 1'b0; irq_serial = 1'b0; irq_joypad = 1'b0;
        clear_interrupt_flag = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic write_reg(input logic [15:0] a, input logic [7:0] d);
        addr_i = a; data_i = d; wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic read_check(input string name, input logic [15:0] a, input logic [7:0] exp);
        addr_i = a;
        #1;
        check(name, {8'h00, data_o}, {8'h00, exp});
    endtask

    // Reset, TAC=05, TMA=AA, TIMA=FE, then run until TIMA reads 00 (the OVF cycle).
    task automatic setup_ovf(input string name);
        bit found;
        found = 1'b0;
        do_reset();
        write_reg(16'hFF07, 8'h05);
        write_reg(16'hFF06, 8'hAA);
        write_reg(16'hFF05, 8'hFE);
        for (int i = 0; i < 40; i++) begin
            addr_i = 16'hFF05;
            #1;
            if (data_o == 8'h00) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        check({name, "_reach_ovf"}, {15'd0, found}, 16'd1);
    endtask

    // ---------------- reference model ----------------
    int m_cnt, m_tima, m_tma, m_tac, m_if, m_ie, m_prev;
    int m_phase;  // 0 counting, 1 just wrapped, 2 reloading

    function automatic int m_read(input logic [15:0] a);
        case (a)
            16'hFF04: return m_cnt / 256;
            16'hFF05: return m_tima;
            16'hFF06: return m_tma;
            16'hFF07: return 248 + m_tac;
            16'hFF0F: return 224 + m_if;
            16'hFFFF: return m_ie;
            default:  return 255;
        endcase
    endfunction

    function automatic bit m_sel(input logic [15:0] a);
        return (a == 16'hFF04) || (a == 16'hFF05) || (a == 16'hFF06) ||
               (a == 16'hFF07) || (a == 16'hFF0F) || (a == 16'hFFFF);
    endfunction

    task automatic model_step();
        int bit_pos, base, set_timer, sig, fall, d;
        bit w_div, w_tima, w_tma, w_tac, w_if, w_ie, done;
        if (reset) begin
            m_cnt = 0; m_tima = 0; m_tma = 0; m_tac = 0; m_if = 0; m_ie = 0;
            m_prev = 0; m_phase = 0;
            return;
        end
        d      = int'(data_i);
        w_div  = wr_en && addr_i == 16'hFF04;
        w_tima = wr_en && addr_i == 16'hFF05;
        w_tma  = wr_en && addr_i == 16'hFF06;
        w_tac  = wr_en && addr_i == 16'hFF07;
        w_if   = wr_en && addr_i == 16'hFF0F;
        w_ie   = wr_en && addr_i == 16'hFFFF;
        case (m_tac % 4)
            0:       bit_pos = 9;
            1:       bit_pos = 3;
            2:       bit_pos = 5;
            default: bit_pos = 7;
        endcase
        sig  = (m_tac >= 4) ? (m_cnt >> bit_pos) % 2 : 0;
        fall = (m_prev == 1 && sig == 0) ? 1 : 0;
        set_timer = 0;
        if (m_phase == 1) begin
            if (w_tima) begin
                m_tima = d; m_phase = 0;
            end else begin
                m_tima = m_tma; set_timer = 1; m_phase = 2;
            end
        end else if (m_phase == 2) begin
            if (w_tma) m_tima = d;
            m_phase = 0;
        end else if (w_tima) begin
            m_tima = d;
        end else if (fall == 1) begin
            m_tima = (m_tima + 1) % 256;
            if (m_tima == 0) m_phase = 1;
        end
        if (w_if) begin
            base = d % 32;
        end else begin
            base = m_if;
            done = 1'b0;
            if (clear_interrupt_flag) begin
                for (int i = 0; i < 5; i++) begin
                    if (!done && ((base >> i) % 2 == 1)) begin
                        base = base - (1 << i);
                        done = 1'b1;
                    end
                end
            end
        end
        m_if = base | int'(irq_vblank) | (int'(irq_stat) * 2) | (set_timer * 4)
                    | (int'(irq_serial) * 8) | (int'(irq_joypad) * 16);
        m_cnt  = w_div ? 0 : (m_cnt + 4) % 65536;
        m_prev = sig;
        if (w_tma) m_tma = d;
        if (w_tac) m_tac = d % 8;
        if (w_ie)  m_ie  = d;
    endtask

    // ---------------- register table ----------------
    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [7:0]  data;
        logic [7:0]  exp;
        logic        exp_sel;
    } vec_t;

    vec_t vecs[12];

    initial begin
        int t_ff, t_00;
        logic [15:0] addr_pool[8];

        idle_inputs();
        vecs[0]  = '{1'b1, 16'hFF05, 8'h12, 8'h12, 1'b1};
        vecs[1]  = '{1'b1, 16'hFF06, 8'h5A, 8'h5A, 1'b1};
        vecs[2]  = '{1'b1, 16'hFFFF, 8'h3C, 8'h3C, 1'b1};
        vecs[3]  = '{1'b1, 16'hFF07, 8'hFD, 8'hFD, 1'b1};
        vecs[4]  = '{1'b1, 16'hFF07, 8'h0A, 8'hFA, 1'b1};
        vecs[5]  = '{1'b1, 16'hFF0F, 8'hE5, 8'hE5, 1'b1};
        vecs[6]  = '{1'b1, 16'hFF10, 8'h00, 8'hFF, 1'b0};
        vecs[7]  = '{1'b0, 16'hFFFF, 8'h00, 8'h3C, 1'b1};
        vecs[8]  = '{1'b0, 16'hFF06, 8'h00, 8'h5A, 1'b1};
        vecs[9]  = '{1'b1, 16'hFF04, 8'h77, 8'h00, 1'b1};
        vecs[10] = '{1'b0, 16'hFF0F, 8'h00, 8'hE5, 1'b1};
        vecs[11] = '{1'b0, 16'h0000, 8'h00, 8'hFF, 1'b0};

        // Reset state
        do_reset();
        check("rst_reg_IF", {8'h00, reg_IF}, 16'h0000);
        check("rst_reg_IE", {8'h00, reg_IE}, 16'h0000);
        check("rst_fsm", {14'd0, fsm_state}, 16'd0);
        read_check("rst_div", 16'hFF04, 8'h00);
        read_check("rst_tima", 16'hFF05, 8'h00);
        read_check("rst_tac", 16'hFF07, 8'hF8);
        read_check("rst_if", 16'hFF0F, 8'hE0);

        // Register table
        for (int i = 0; i < 12; i++) begin
            if (vecs[i].wr) write_reg(vecs[i].addr, vecs[i].data);
            read_check($sformatf("vec%0d_data", i), vecs[i].addr, vecs[i].exp);
            check($sformatf("vec%0d_sel", i), {15'd0, sel_o}, {15'd0, vecs[i].exp_sel});
        end
        check("vec_reg_IF", {8'h00, reg_IF}, 16'h0005);

        // Overflow and reload timing
        do_reset();
        write_reg(16'hFF07, 8'h05);
        write_reg(16'hFF06, 8'hAA);
        write_reg(16'hFF05, 8'hFE);
        t_ff = -1; t_00 = -1;
        for (int i = 0; i < 40; i++) begin
            addr_i = 16'hFF05;
            #1;
            if (data_o == 8'hFF && t_ff < 0) t_ff = i;
            if (data_o == 8'h00) begin
                t_00 = i;
                break;
            end
            tick();
        end
        check("ovf_step_cycles", 16'(t_00 - t_ff), 16'd4);
        check("ovf_fsm", {14'd0, fsm_state}, 16'd1);
        check("ovf_reg_IF", {8'h00, reg_IF}, 16'h0000);
        tick();
        read_check("reload_tima", 16'hFF05, 8'hAA);
        check("reload_reg_IF", {8'h00, reg_IF}, 16'h0004);
        check("reload_fsm", {14'd0, fsm_state}, 16'd2);
        tick();
        check("after_reload_fsm", {14'd0, fsm_state}, 16'd0);

        // TIMA write in OVF cancels reload
        setup_ovf("cancel");
        write_reg(16'hFF05, 8'h33);
        read_check("cancel_tima", 16'hFF05, 8'h33);
        check("cancel_fsm", {14'd0, fsm_state}, 16'd0);
        tick();
        check("cancel_reg_IF", {8'h00, reg_IF}, 16'h0000);

        // TMA write in RELOAD lands in TIMA
        setup_ovf("tma_reload");
        tick();
        write_reg(16'hFF06, 8'h55);
        read_check("tma_reload_tima", 16'hFF05, 8'h55);
        read_check("tma_reload_tma", 16'hFF06, 8'h55);

        // TIMA write in RELOAD ignored
        setup_ovf("tima_reload");
        tick();
        write_reg(16'hFF05, 8'h77);
        read_check("tima_reload_ignored", 16'hFF05, 8'hAA);

        // Reset in OVF and in RELOAD aborts the reload
        setup_ovf("rst_ovf");
        do_reset();
        tick(); tick();
        check("rst_ovf_reg_IF", {8'h00, reg_IF}, 16'h0000);
        read_check("rst_ovf_tima", 16'hFF05, 8'h00);
        setup_ovf("rst_reload");
        tick();
        do_reset();
        tick();
        check("rst_reload_reg_IF", {8'h00, reg_IF}, 16'h0000);
        check("rst_reload_fsm", {14'd0, fsm_state}, 16'd0);

        // DIV after 256 cycles and the DIV-write falling edge
        do_reset();
        for (int i = 0; i < 256; i++) tick();
        read_check("div_256", 16'hFF04, 8'h04);
        write_reg(16'hFF04, 8'h9C);
        read_check("div_cleared", 16'hFF04, 8'h00);
        write_reg(16'hFF07, 8'h05);
        tick();
        read_check("div_edge_before", 16'hFF05, 8'h00);
        write_reg(16'hFF04, 8'h00);
        read_check("div_edge_pending", 16'hFF05, 8'h00);
        tick();
        read_check("div_edge_inc", 16'hFF05, 8'h01);

        // Interrupt flags and priority clear
        do_reset();
        write_reg(16'hFFFF, 8'hFF);
        irq_vblank = 1'b1; irq_serial = 1'b1;
        tick();
        irq_vblank = 1'b0; irq_serial = 1'b0;
        check("irq_reg_IF", {8'h00, reg_IF}, 16'h0009);
        read_check("irq_ff0f", 16'hFF0F, 8'hE9);
        clear_interrupt_flag = 1'b1;
        tick();
        check("clr1_reg_IF", {8'h00, reg_IF}, 16'h0008);
        tick();
        clear_interrupt_flag = 1'b0;
        check("clr2_reg_IF", {8'h00, reg_IF}, 16'h0000);

        // Set beats clear; reset beats write
        irq_vblank = 1'b1;
        tick();
        check("set_if01", {8'h00, reg_IF}, 16'h0001);
        clear_interrupt_flag = 1'b1;
        tick();
        irq_vblank = 1'b0; clear_interrupt_flag = 1'b0;
        check("set_beats_clear", {8'h00, reg_IF}, 16'h0001);
        reset = 1'b1; irq_joypad = 1'b1;
        addr_i = 16'hFF0F; data_i = 8'h1F; wr_en = 1'b1;
        tick();
        idle_inputs();
        check("rst_beats_write", {8'h00, reg_IF}, 16'h0000);
        check("rst_beats_write_IE", {8'h00, reg_IE}, 16'h0000);

        // Random traffic against the reference model
        addr_pool[0] = 16'hFF04; addr_pool[1] = 16'hFF05; addr_pool[2] = 16'hFF06;
        addr_pool[3] = 16'hFF07; addr_pool[4] = 16'hFF0F; addr_pool[5] = 16'hFFFF;
        addr_pool[6] = 16'hFF05; addr_pool[7] = 16'hFF10;
        reset = 1'b1;
        model_step();
        tick();
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 9) == 0) addr_i = 16'($urandom);
            else addr_i = addr_pool[$urandom_range(0, 7)];
            wr_en = ($urandom_range(0, 3) == 0);
            if (addr_i == 16'hFF04) wr_en = wr_en && ($urandom_range(0, 7) == 0);
            data_i = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(250, 255)) : 8'($urandom);
            irq_vblank = ($urandom_range(0, 7) == 0);
            irq_stat   = ($urandom_range(0, 7) == 0);
            irq_serial = ($urandom_range(0, 7) == 0);
            irq_joypad = ($urandom_range(0, 7) == 0);
            clear_interrupt_flag = ($urandom_range(0, 5) == 0);
            #1;
            check("rnd_data_o", {8'h00, data_o}, 16'(m_read(addr_i)));
            check("rnd_sel_o", {15'd0, sel_o}, {15'd0, m_sel(addr_i)});
            check("rnd_reg_IF", {8'h00, reg_IF}, 16'(m_if));
            check("rnd_reg_IE", {8'h00, reg_IE}, 16'(m_ie));
            model_step();
            tick();
        end
        idle_inputs();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/gb_interrupt_timer.md
GB_INTERRUPT_TIMER -- requirements
Module: gb_interrupt_timer

Interface
REQ-001 SHALL expose clk  input  1  M-cycle clock; the only clock, all state updates on its rising edge.
REQ-002 SHALL expose reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-003 SHALL expose addr_i  input  16  CPU address bus (CPU addr_o).
REQ-004 SHALL expose data_i  input  8  CPU write data (CPU data_o).
REQ-005 SHALL expose wr_en  input  1  CPU write strobe (CPU drive_data_bus); a write takes effect at the next rising edge.
REQ-006 SHALL expose data_o  output  8  read data for the addressed register, combinational; 8'hFF when not selected.
REQ-007 SHALL expose sel_o  output  1  high when addr_i is one of FF04, FF05, FF06, FF07, FF0F, FFFF; combinational.
REQ-008 SHALL expose irq_vblank, irq_stat, irq_serial, irq_joypad  input  1 each  one-cycle request pulses for IF bits 0, 1, 3, 4.
REQ-009 SHALL expose clear_interrupt_flag  input  1  CPU request to clear the highest-priority pending IF bit.
REQ-010 SHALL expose reg_IF  output  8  {3'b000, IF[4:0]}, registered; feeds the CPU reg_IF input.
REQ-011 SHALL expose reg_IE  output  8  full 8-bit IE register, registered; feeds the CPU reg_IE input.

Function
REQ-012 Internal 16-bit system counter SHALL add 4 every cycle and wrap modulo 2^16; DIV (FF04) reads counter[15:8].
REQ-013 Any write to FF04 SHALL clear the counter to 0 in that cycle instead of incrementing it; data_i is ignored.
REQ-014 Timer signal SHALL be TAC[2] AND counter[b], b = 9/3/5/7 for TAC[1:0] = 00/01/10/11, computed from the registered counter.
REQ-015 A 1-bit register SHALL hold the previous timer signal; a 1-to-0 transition SHALL increment TIMA by 1 (8-bit).
REQ-016 Falling edges caused by a DIV write, a TAC enable clear, or a TAC select change SHALL increment TIMA like any other falling edge.
REQ-017 Overflow FSM states SHALL be RUN, OVF and RELOAD; reset state RUN.
REQ-018 RUN->OVF SHALL occur when TIMA increments from FF; TIMA becomes 00.
REQ-019 In OVF (1 cycle), TIMA SHALL read 00; OVF->RELOAD on the next edge, loading TIMA=TMA and setting IF[2].
REQ-020 A CPU write to TIMA while in OVF SHALL store data_i, cancel the reload and the IF[2] set, and return to RUN.
REQ-021 In RELOAD (1 cycle), CPU writes to TIMA SHALL be ignored; a TMA write in this cycle SHALL also be loaded into TIMA; RELOAD->RUN always.
REQ-022 A TIMA write in RUN SHALL take priority over a same-cycle increment.
REQ-023 TMA SHALL be 8 bits, read/write; TAC SHALL store bits [2:0] and read as {5'b11111, TAC[2:0]}.
REQ-024 IF SHALL be 5 bits and read at FF0F as {3'b111, IF[4:0]}; IE SHALL be 8 bits, read/write at FFFF.
REQ-025 clear_interrupt_flag SHALL clear the lowest-numbered set bit of IF[4:0], ignoring IE; no-op when IF is 0.
REQ-026 Next IF SHALL be (CPU write value if FF0F is written, else IF with the clear applied) OR the current-cycle request pulses OR the timer set; setting a bit always wins.
REQ-027 Reads SHALL have no side effects; wr_en to an unselected address SHALL change nothing.

Reset
REQ-028 On reset: counter=0000, TIMA=00, TMA=00, TAC=0, IF=0, IE=00, previous timer signal=0, FSM=RUN; so reg_IF=00, reg_IE=00, DIV reads 00.
REQ-029 Reset SHALL take priority over all writes, request pulses and clear_interrupt_flag in the same cycle.
REQ-030 Reset asserted in OVF or RELOAD SHALL abort the reload, with no IF[2] set afterwards.

Verification
REQ-031 Reset, TAC=05, TMA=AA, TIMA=FE, run -> TIMA steps every 4 cycles to FF then 00; 00 is held 1 cycle; next cycle TIMA=AA and reg_IF=04.
REQ-032 Same setup, write TIMA=33 during the OVF cycle -> TIMA=33, reg_IF stays 00, FSM returns to RUN.
REQ-033 Same setup, write TMA=55 during the RELOAD cycle -> TIMA=55; a TIMA write of 77 in that cycle is ignored.
REQ-034 Reset, 256 idle cycles -> FF04 reads 04; write FF04 -> reads 00 next cycle; with TAC=05 and counter[3]=1 the write increments TIMA by 1.
REQ-035 Pulse irq_vblank and irq_serial, IE=FF -> reg_IF=09, FF0F reads E9; clear_interrupt_flag -> reg_IF=08; next clear -> 00.
REQ-036 clear_interrupt_flag with irq_vblank in the same cycle while IF=01 -> IF stays 01; write FF0F=1F with reset asserted -> IF=00.
